uart_baud_ctrl: RTL and testbench

Sequencer that reprograms the UART fractional baud divider at run time. It accepts a requested baud rate over a valid/ready handshake and computes the integer divisor and fractional-add settings with a multi-cycle serial divider. It then waits for the UART datapath to go idle, holds the divider in reset while the new settings are applied, and releases it. It sits between the UART CSR block and the divider/TX/RX logic.

---
 rtl/uart_baud_ctrl.sv | 175 +++++++++++++++++
 tb/tb_uart_baud_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_ctrl.sv
// Run-time baud reprogramming sequencer: serial divide of SYS_CLK_HZ by baud*16, wait for idle, apply under divider reset.
// Optional macro UART_BAUD_TIMEOUT_EN bounds the idle wait to WAIT_TIMEOUT cycles.
module uart_baud_ctrl #(
   parameter logic [31:0] SYS_CLK_HZ     = 32'd50000000,
   parameter int unsigned RST_HOLD       = 4,
   parameter logic [15:0] RST_DIV        = 16'd27,
   parameter logic [4:0]  RST_FRAG_TOTAL = 5'd2,
   parameter logic [3:0]  RST_FRAG_I     = 4'd7,
   parameter int unsigned WAIT_TIMEOUT   = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_valid,
   input  logic [23:0] cfg_baud,
   output logic        cfg_ready,
   output logic        cfg_done,
   output logic        cfg_err,
   input  logic        uart_busy,
   output logic        div_rst_n,
   output logic [15:0] uart_clk_div,
   output logic [4:0]  uart_clk_frag_total,
   output logic [3:0]  uart_clk_frag_i
);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_CHECK = 4'd1;
   localparam logic [3:0] S_DIV1  = 4'd2;
   localparam logic [3:0] S_DIV2  = 4'd3;
   localparam logic [3:0] S_RANGE = 4'd4;
   localparam logic [3:0] S_WAIT  = 4'd5;
   localparam logic [3:0] S_APPLY = 4'd6;
   localparam logic [3:0] S_DONE  = 4'd7;
   localparam logic [3:0] S_ERR   = 4'd8;

   logic [3:0]  r_state, w_next;
   logic [23:0] r_baud;
   logic [31:0] r_dvd, r_quo;
   logic [28:0] r_rem;
   logic [3:0]  r_ft, r_hold, w_frag_i;
   logic [4:0]  r_step;
   logic [27:0] w_denom;
   logic [28:0] w_rem_sh, w_rem_nx;
   logic        w_ge, w_q_bad, w_timeout;
   logic        r_ready, r_done, r_err, r_div_rst_n;
   logic [15:0] r_div;
   logic [4:0]  r_frag_total;
   logic [3:0]  r_frag_i;

   assign w_denom  = {r_baud, 4'd0};
   // DIV1 shifts in dividend bits; DIV2 continues the same remainder with zeros to get r*16/denom
   assign w_rem_sh = (r_state == S_DIV1) ? {r_rem[27:0], r_dvd[31]} : {r_rem[27:0], 1'b0};
   assign w_ge     = (w_rem_sh >= {1'b0, w_denom});
   assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, w_denom}) : w_rem_sh;
   assign w_q_bad  = (r_quo < 32'd2) || (r_quo > 32'd65535);

`ifdef UART_BAUD_TIMEOUT_EN
   logic [15:0] r_wait_cnt;
   assign w_timeout = (r_wait_cnt == 16'(WAIT_TIMEOUT - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_wait_cnt <= '0;
      else if (r_state == S_WAIT && uart_busy)
         r_wait_cnt <= r_wait_cnt + 16'd1;
      else
         r_wait_cnt <= '0;
   end
`else
   logic w_unused_timeout;
   assign w_timeout        = 1'b0;
   assign w_unused_timeout = (WAIT_TIMEOUT == 0);
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (cfg_valid) w_next = S_CHECK;
         S_CHECK: w_next = (r_baud == 24'd0) ? S_ERR : S_DIV1;
         S_DIV1:  if (r_step == 5'd31) w_next = S_DIV2;
         S_DIV2:  if (r_step == 5'd3) w_next = S_RANGE;
         S_RANGE: w_next = w_q_bad ? S_ERR : S_WAIT;
         S_WAIT: begin
            if (!uart_busy)     w_next = S_APPLY;
            else if (w_timeout) w_next = S_ERR;
         end
         S_APPLY: if (r_hold == 4'(RST_HOLD - 1)) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_frag_i = 4'd0;
      case (r_ft)
         4'd0, 4'd1: w_frag_i = 4'd15;
         4'd2:       w_frag_i = 4'd7;
         4'd3:       w_frag_i = 4'd4;
         4'd4:       w_frag_i = 4'd3;
         4'd5:       w_frag_i = 4'd2;
         4'd6, 4'd7: w_frag_i = 4'd1;
         default:    w_frag_i = 4'd0;
      endcase
   end

   // Status outputs are registered from the next state so they never glitch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ready     <= 1'b1;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_div_rst_n <= 1'b1;
      end else begin
         r_state     <= w_next;
         r_ready     <= (w_next == S_IDLE);
         r_done      <= (w_next == S_DONE);
         r_err       <= (w_next == S_ERR);
         r_div_rst_n <= (w_next != S_APPLY);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_baud       <= '0;
         r_dvd        <= '0;
         r_quo        <= '0;
         r_rem        <= '0;
         r_ft         <= '0;
         r_step       <= '0;
         r_hold       <= '0;
         r_div        <= RST_DIV;
         r_frag_total <= RST_FRAG_TOTAL;
         r_frag_i     <= RST_FRAG_I;
      end else begin
         case (r_state)
            S_IDLE: if (cfg_valid) begin
               r_baud <= cfg_baud;
               r_dvd  <= SYS_CLK_HZ;
               r_quo  <= '0;
               r_rem  <= '0;
               r_ft   <= '0;
               r_step <= '0;
            end
            S_DIV1: begin
               r_rem  <= w_rem_nx;
               r_dvd  <= {r_dvd[30:0], 1'b0};
               r_quo  <= {r_quo[30:0], w_ge};
               r_step <= r_step + 5'd1;
            end
            S_DIV2: begin
               r_rem  <= w_rem_nx;
               r_ft   <= {r_ft[2:0], w_ge};
               r_step <= r_step + 5'd1;
            end
            S_WAIT: if (!uart_busy) begin
               r_div        <= r_quo[15:0];
               r_frag_total <= {1'b0, r_ft};
               r_frag_i     <= w_frag_i;
               r_hold       <= '0;
            end
            S_APPLY: r_hold <= r_hold + 4'd1;
            default: ;
         endcase
      end
   end

   assign cfg_ready           = r_ready;
   assign cfg_done            = r_done;
   assign cfg_err             = r_err;
   assign div_rst_n           = r_div_rst_n;
   assign uart_clk_div        = r_div;
   assign uart_clk_frag_total = r_frag_total;
   assign uart_clk_frag_i     = r_frag_i;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Scoreboard bench for uart_baud_ctrl: stimulus pushes expected responses from an arithmetic model, a monitor pops on cfg_done/cfg_err.
module tb_uart_baud_ctrl;

   localparam logic [31:0] SYS  = 32'd50000000;
   localparam int unsigned HOLD = 4;
   localparam int unsigned WT   = 50;

   logic        clk = 1'b0;
   logic        rst_n, cfg_valid, uart_busy;
   logic [23:0] cfg_baud;
   logic        cfg_ready, cfg_done, cfg_err, div_rst_n;
   logic [15:0] uart_clk_div;
   logic [4:0]  uart_clk_frag_total;
   logic [3:0]  uart_clk_frag_i;

   always #5 clk = ~clk;

   uart_baud_ctrl #(
      .SYS_CLK_HZ(SYS), .RST_HOLD(HOLD), .RST_DIV(16'd27),
      .RST_FRAG_TOTAL(5'd2), .RST_FRAG_I(4'd7), .WAIT_TIMEOUT(WT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_baud(cfg_baud),
      .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err),
      .uart_busy(uart_busy), .div_rst_n(div_rst_n), .uart_clk_div(uart_clk_div),
      .uart_clk_frag_total(uart_clk_frag_total), .uart_clk_frag_i(uart_clk_frag_i)
   );

   typedef struct {
      bit          is_err;
      int          acc_cyc;
      int          lat;
      logic [15:0] div;
      logic [4:0]  ft;
      logic [3:0]  fi;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0, n_fail = 0, cyc = 0, resp_cnt = 0, push_cnt = 0, low_cnt = 0;
   logic [15:0] m_div = 16'd27;
   logic [4:0]  m_ft  = 5'd2;
   logic [3:0]  m_fi  = 4'd7;
   int fi_tab[16] = '{15, 15, 7, 4, 3, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected outcome from the arithmetic rules; busy_cyc is the edge index at which busy is first seen low
   function automatic exp_t model(input logic [23:0] baud, input int busy_cyc);
      exp_t e;
      longint unsigned den, q, r, ftv;
      int b;
      e.is_err = 1'b1; e.acc_cyc = 0; e.lat = 0;
      e.div = m_div; e.ft = m_ft; e.fi = m_fi;
      den = longint'(baud) * 16;
      if (baud == 24'd0) begin
         e.lat = 1;
      end else begin
         q = SYS / den;
         r = SYS % den;
         if (q < 2 || q > 65535) begin
            e.lat = 38;
         end else begin
`ifdef UART_BAUD_TIMEOUT_EN
            if (busy_cyc > 38 + int'(WT)) begin
               e.lat = 38 + int'(WT);
               return e;
            end
`endif
            ftv      = (r * 16) / den;
            b        = (busy_cyc > 39) ? busy_cyc : 39;
            e.is_err = 1'b0;
            e.lat    = b + int'(HOLD);
            e.div    = q[15:0];
            e.ft     = 5'(ftv);
            e.fi     = 4'(fi_tab[int'(ftv)]);
         end
      end
      return e;
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (!div_rst_n) low_cnt++;
         if (cfg_done || cfg_err) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_resp: done=%0b err=%0b with empty scoreboard", cfg_done, cfg_err);
            end else begin
               e = sb.pop_front();
               chk("resp_is_err", cfg_err, e.is_err);
               chk("resp_done", cfg_done, !e.is_err);
               chk("latency", cyc - e.acc_cyc, e.lat);
               chk("clk_div", uart_clk_div, e.div);
               chk("frag_total", uart_clk_frag_total, e.ft);
               chk("frag_i", uart_clk_frag_i, e.fi);
               chk("div_rst_low_cycles", low_cnt, e.is_err ? 0 : HOLD);
            end
            low_cnt = 0;
            resp_cnt++;
         end
      end
   end

   task automatic do_req(input logic [23:0] baud, input int busy_cyc, input bit hold_valid);
      exp_t e;
      int n, start;
      e = model(baud, busy_cyc);
      uart_busy = (busy_cyc > 0);
      cfg_baud  = baud;
      cfg_valid = 1'b1;
      e.acc_cyc = cyc + 1;
      sb.push_back(e);
      push_cnt++;
      if (!e.is_err) begin
         m_div = e.div; m_ft = e.ft; m_fi = e.fi;
      end
      start = resp_cnt;
      @(posedge clk); #1;
      if (!hold_valid) begin
         cfg_valid = 1'b0;
         cfg_baud  = 24'($urandom);
      end
      n = 0;
      while (resp_cnt == start && n < 600) begin
         @(negedge clk); #1;
         n++;
         if (n >= busy_cyc) uart_busy = 1'b0;
      end
      cfg_valid = 1'b0;
      uart_busy = 1'b0;
      if (resp_cnt == start) begin
         n_checks++;
         n_fail++;
         $display("FAIL resp_timeout: no cfg_done/cfg_err within %0d cycles for baud %0d", n, baud);
         sb.delete();
      end
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_div"}, uart_clk_div, 27);
      chk({tag, "_frag_total"}, uart_clk_frag_total, 2);
      chk({tag, "_frag_i"}, uart_clk_frag_i, 7);
      chk({tag, "_div_rst_n"}, div_rst_n, 1);
      chk({tag, "_ready"}, cfg_ready, 1);
      chk({tag, "_done"}, cfg_done, 0);
      chk({tag, "_err"}, cfg_err, 0);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] baud;
      int busy;
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_baud = '0; uart_busy = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk); #1;

      do_req(24'd9600, 0, 1'b0);
      do_req(24'd115200, 100, 1'b0);
      do_req(24'd0, 0, 1'b0);
      do_req(24'd2000000, 0, 1'b0);
      do_req(24'd19200, 0, 1'b1);
      do_req(24'd47, 0, 1'b0);
      do_req(24'd1562500, 0, 1'b0);
      do_req(24'd57600, 200, 1'b0);

      // Abort during the divide: reset values must come back with no partial apply
      cfg_baud = 24'd9600; cfg_valid = 1'b1;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      repeat (10) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      sb.delete();
      low_cnt = 0;
      m_div = 16'd27; m_ft = 5'd2; m_fi = 4'd7;
      check_reset_vals("midreset");
      @(negedge clk); #1 rst_n = 1'b1;
      @(negedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         case ($urandom_range(0, 9))
            0:       baud = 24'd0;
            1:       baud = 24'($urandom_range(1, 47));
            2:       baud = 24'($urandom_range(1562501, 16777215));
            default: baud = 24'($urandom_range(48, 1562500));
         endcase
         busy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 80)) : 0;
         do_req(baud, busy, 1'($urandom_range(0, 1)));
      end

      chk("sb_empty", sb.size(), 0);
      chk("resp_count", resp_cnt, push_cnt);
      chk("final_ready", cfg_ready, 1);
      chk("final_div_rst_n", div_rst_n, 1);
      chk("final_div", uart_clk_div, m_div);
      chk("final_frag_total", uart_clk_frag_total, m_ft);
      chk("final_frag_i", uart_clk_frag_i, m_fi);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
